// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer: autonomous frame driver for an LED matrix chain.
// Walks every column through a 74HC595-style select chain, then streams
// WORDS_PER_COLUMN words per lane on CHANNEL_NUMBER parallel MOSI lanes with
// a divided SPI clock. Column drivers are blanked while the select chain moves.
module matrix_frame_sequencer #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int MSB_FIRST        = 1,
  parameter int COLUMN_COUNT     = 16,
  parameter int WORDS_PER_COLUMN = 24,
  parameter int CLK_DIV          = 2,
  localparam int COL_W = (COLUMN_COUNT > 1) ? $clog2(COLUMN_COUNT) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  input  logic                               extra_bit,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_in,
  input  logic                               data_valid,
  output logic                               data_ready,
  output logic                               busy,
  output logic [COL_W-1:0]                   column_idx,
  output logic                               frame_done,
  output logic                               spi_clk,
  output logic [CHANNEL_NUMBER-1:0]          spi_mosi,
  output logic                               ser_clk,
  output logic                               ser_data,
  output logic                               ser_stcp,
  output logic                               ser_n_enable
);

  localparam int WORD_W = $clog2(WORDS_PER_COLUMN + 1);
  localparam int BIT_W  = $clog2(SPI_SIZE + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COL_SHIFT0 = 3'd1,
    ST_COL_SHIFT1 = 3'd2,
    ST_COL_LATCH  = 3'd3,
    ST_LOAD       = 3'd4,
    ST_BIT_LO     = 3'd5,
    ST_BIT_HI     = 3'd6,
    ST_COL_END    = 3'd7
  } state_t;

  state_t                                    state_q, state_d;
  logic                                      phase_q, phase_d;
  logic [COL_W-1:0]                          col_q, col_d;
  logic [WORD_W-1:0]                         word_q, word_d;
  logic [WORD_W-1:0]                         word_inc_s;
  logic [BIT_W-1:0]                          bit_q, bit_d;
  logic [DIV_W-1:0]                          div_q, div_d;
  logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0]   shreg_q, shreg_d;

  logic                                      busy_q, busy_d;
  logic                                      ready_q, ready_d;
  logic                                      done_q, done_d;
  logic                                      sclk_q, sclk_d;
  logic [CHANNEL_NUMBER-1:0]                 mosi_q, mosi_d;
  logic                                      ser_clk_q, ser_clk_d;
  logic                                      ser_data_q, ser_data_d;
  logic                                      stcp_q, stcp_d;
  logic                                      nen_q, nen_d;

  // Bit that is on the wire for a lane, given the remaining shift contents.
  function automatic logic lead_bit(input logic [SPI_SIZE-1:0] w);
    if (MSB_FIRST != 0) lead_bit = w[SPI_SIZE-1];
    else                lead_bit = w[0];
  endfunction

  // Advance a lane word so the next bit becomes the lead bit.
  function automatic logic [SPI_SIZE-1:0] shift_word(input logic [SPI_SIZE-1:0] w);
    if (MSB_FIRST != 0) shift_word = w << 1;
    else                shift_word = w >> 1;
  endfunction

  assign word_inc_s = word_q + WORD_W'(1);

  // Next-state and counter logic of the frame walker.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    word_d  = word_q;
    bit_d   = bit_q;
    div_d   = div_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_COL_SHIFT0;
          col_d   = {COL_W{1'b0}};
          phase_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COL_SHIFT0, ST_COL_SHIFT1: begin
        // Each shifted bit takes a low and a high ser_clk cycle.
        if (phase_q == 1'b0) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = (state_q == ST_COL_SHIFT0) ? ST_COL_SHIFT1 : ST_COL_LATCH;
        end
      end
      ST_COL_LATCH: begin
        state_d = ST_LOAD;
        word_d  = {WORD_W{1'b0}};
      end
      ST_LOAD: begin
        if (data_valid) begin
          shreg_d = data_in;
          bit_d   = {BIT_W{1'b0}};
          div_d   = {DIV_W{1'b0}};
          state_d = ST_BIT_LO;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_BIT_LO: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = {DIV_W{1'b0}};
          state_d = ST_BIT_HI;
        end else begin
          div_d   = div_q + DIV_W'(1);
        end
      end
      ST_BIT_HI: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = {DIV_W{1'b0}};
          if (bit_q == BIT_W'(SPI_SIZE - 1)) begin
            word_d  = word_inc_s;
            state_d = (word_inc_s == WORD_W'(WORDS_PER_COLUMN)) ? ST_COL_END : ST_LOAD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = ST_BIT_LO;
            for (int k = 0; k < CHANNEL_NUMBER; k++) begin
              shreg_d[k] = shift_word(shreg_q[k]);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_COL_END: begin
        if (col_q == COL_W'(COLUMN_COUNT - 1)) begin
          col_d   = {COL_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          col_d   = col_q + COL_W'(1);
          phase_d = 1'b0;
          state_d = ST_COL_SHIFT0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so pins are flop-driven.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    ready_d    = (state_d == ST_LOAD);
    done_d     = (state_d == ST_COL_END) && (col_d == COL_W'(COLUMN_COUNT - 1));
    sclk_d     = (state_d == ST_BIT_HI);
    stcp_d     = (state_d == ST_COL_LATCH);
    ser_clk_d  = ((state_d == ST_COL_SHIFT0) || (state_d == ST_COL_SHIFT1)) && phase_d;
    mosi_d     = {CHANNEL_NUMBER{1'b0}};
    ser_data_d = 1'b0;
    nen_d      = nen_q;
    if ((state_d == ST_BIT_LO) || (state_d == ST_BIT_HI)) begin
      for (int k = 0; k < CHANNEL_NUMBER; k++) begin
        mosi_d[k] = lead_bit(shreg_d[k]);
      end
    end else begin
      mosi_d = {CHANNEL_NUMBER{1'b0}};
    end
    if (state_d == ST_COL_SHIFT0) begin
      ser_data_d = (col_d == {COL_W{1'b0}});
    end else if (state_d == ST_COL_SHIFT1) begin
      // extra_bit is sampled on entry and held through the ser_clk high half.
      ser_data_d = phase_d ? ser_data_q : extra_bit;
    end else begin
      ser_data_d = 1'b0;
    end
    // Blank while the column chain moves; IDLE keeps whatever the last frame left.
    if ((state_d == ST_COL_SHIFT0) || (state_d == ST_COL_SHIFT1) || (state_d == ST_COL_LATCH)) begin
      nen_d = 1'b1;
    end else if (state_d == ST_IDLE) begin
      nen_d = nen_q;
    end else begin
      nen_d = 1'b0;
    end
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      col_q      <= {COL_W{1'b0}};
      word_q     <= {WORD_W{1'b0}};
      bit_q      <= {BIT_W{1'b0}};
      div_q      <= {DIV_W{1'b0}};
      shreg_q    <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= {CHANNEL_NUMBER{1'b0}};
      ser_clk_q  <= 1'b0;
      ser_data_q <= 1'b0;
      stcp_q     <= 1'b0;
      nen_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      shreg_q    <= shreg_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ser_clk_q  <= ser_clk_d;
      ser_data_q <= ser_data_d;
      stcp_q     <= stcp_d;
      nen_q      <= nen_d;
    end
  end

  assign data_ready   = ready_q;
  assign busy         = busy_q;
  assign column_idx   = col_q;
  assign frame_done   = done_q;
  assign spi_clk      = sclk_q;
  assign spi_mosi     = mosi_q;
  assign ser_clk      = ser_clk_q;
  assign ser_data     = ser_data_q;
  assign ser_stcp     = stcp_q;
  assign ser_n_enable = nen_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Bench for matrix_frame_sequencer: two instances (MSB-first and LSB-first)
// share one stimulus and are compared every cycle against a frame-level model.
module tb_matrix_frame_sequencer;
  localparam int CH   = 3;
  localparam int SW   = 8;
  localparam int COLS = 3;
  localparam int WPC  = 2;
  localparam int DIV  = 3;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int VW   = 8 + CW + CH;
  localparam logic [CH-1:0] ZL = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start = 1'b0;
  logic extra_bit = 1'b0;
  logic data_valid = 1'b0;
  logic [CH*SW-1:0] data_in = '0;

  logic m_ready, m_busy, m_done, m_sclk, m_sck, m_sdat, m_stcp, m_nen;
  logic [CW-1:0] m_col;
  logic [CH-1:0] m_mosi;
  logic l_ready, l_busy, l_done, l_sclk, l_sck, l_sdat, l_stcp, l_nen;
  logic [CW-1:0] l_col;
  logic [CH-1:0] l_mosi;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  matrix_frame_sequencer #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SW), .MSB_FIRST(1),
    .COLUMN_COUNT(COLS), .WORDS_PER_COLUMN(WPC), .CLK_DIV(DIV)) u_dut_m (
    .clk(clk), .rst(rst), .frame_start(frame_start), .extra_bit(extra_bit),
    .data_in(data_in), .data_valid(data_valid), .data_ready(m_ready), .busy(m_busy),
    .column_idx(m_col), .frame_done(m_done), .spi_clk(m_sclk), .spi_mosi(m_mosi),
    .ser_clk(m_sck), .ser_data(m_sdat), .ser_stcp(m_stcp), .ser_n_enable(m_nen));

  matrix_frame_sequencer #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SW), .MSB_FIRST(0),
    .COLUMN_COUNT(COLS), .WORDS_PER_COLUMN(WPC), .CLK_DIV(DIV)) u_dut_l (
    .clk(clk), .rst(rst), .frame_start(frame_start), .extra_bit(extra_bit),
    .data_in(data_in), .data_valid(data_valid), .data_ready(l_ready), .busy(l_busy),
    .column_idx(l_col), .frame_done(l_done), .spi_clk(l_sclk), .spi_mosi(l_mosi),
    .ser_clk(l_sck), .ser_data(l_sdat), .ser_stcp(l_stcp), .ser_n_enable(l_nen));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic e_busy, e_ready, e_done, e_sclk, e_sck, e_sdat, e_stcp, e_nen;
  logic [CW-1:0] e_col;
  logic [CH-1:0] e_mm, e_ml;

  task automatic put(input logic busy, input logic ready, input int col, input logic done,
                     input logic sclk, input logic [CH-1:0] mm, input logic [CH-1:0] ml,
                     input logic sck, input logic sdat, input logic stcp, input logic nen);
    e_busy = busy; e_ready = ready; e_col = CW'(col); e_done = done; e_sclk = sclk;
    e_mm = mm; e_ml = ml; e_sck = sck; e_sdat = sdat; e_stcp = stcp; e_nen = nen;
  endtask

  task automatic put_reset();
    put(1'b0, 1'b0, 0, 1'b0, 1'b0, ZL, ZL, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  // Expected per-cycle outputs of one frame, entered on the edge that took frame_start.
  task automatic run_frame();
    logic [CH*SW-1:0] w;
    logic sel, xb;
    logic [CH-1:0] mm, ml;
    for (int c = 0; c < COLS; c++) begin
      sel = (c == 0);
      put(1'b1, 1'b0, c, 1'b0, 1'b0, ZL, ZL, 1'b0, sel, 1'b0, 1'b1); tick(); if (!rst) return;
      put(1'b1, 1'b0, c, 1'b0, 1'b0, ZL, ZL, 1'b1, sel, 1'b0, 1'b1); tick(); if (!rst) return;
      xb = extra_bit;
      put(1'b1, 1'b0, c, 1'b0, 1'b0, ZL, ZL, 1'b0, xb, 1'b0, 1'b1); tick(); if (!rst) return;
      put(1'b1, 1'b0, c, 1'b0, 1'b0, ZL, ZL, 1'b1, xb, 1'b0, 1'b1); tick(); if (!rst) return;
      put(1'b1, 1'b0, c, 1'b0, 1'b0, ZL, ZL, 1'b0, 1'b0, 1'b1, 1'b1); tick(); if (!rst) return;
      for (int wd = 0; wd < WPC; wd++) begin
        put(1'b1, 1'b1, c, 1'b0, 1'b0, ZL, ZL, 1'b0, 1'b0, 1'b0, 1'b0); tick(); if (!rst) return;
        while (!data_valid) begin tick(); if (!rst) return; end
        w = data_in;
        for (int b = 0; b < SW; b++) begin
          for (int k = 0; k < CH; k++) begin
            mm[k] = w[k*SW + SW - 1 - b];
            ml[k] = w[k*SW + b];
          end
          for (int d = 0; d < 2*DIV; d++) begin
            put(1'b1, 1'b0, c, 1'b0, (d >= DIV), mm, ml, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(); if (!rst) return;
          end
        end
      end
      put(1'b1, 1'b0, c, (c == COLS-1), 1'b0, ZL, ZL, 1'b0, 1'b0, 1'b0, 1'b0); tick(); if (!rst) return;
    end
    put(1'b0, 1'b0, 0, 1'b0, 1'b0, ZL, ZL, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : model
    put_reset();
    forever begin
      @(posedge clk);
      if (!rst) put_reset();
      else if (frame_start) begin
        run_frame();
        if (!rst) put_reset();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [VW-1:0] act_m, act_l, exp_m, exp_l;
  always @(negedge clk) begin
    act_m = {m_busy, m_ready, m_col, m_done, m_sclk, m_mosi, m_sck, m_sdat, m_stcp, m_nen};
    act_l = {l_busy, l_ready, l_col, l_done, l_sclk, l_mosi, l_sck, l_sdat, l_stcp, l_nen};
    exp_m = {e_busy, e_ready, e_col, e_done, e_sclk, e_mm, e_sck, e_sdat, e_stcp, e_nen};
    exp_l = {e_busy, e_ready, e_col, e_done, e_sclk, e_ml, e_sck, e_sdat, e_stcp, e_nen};
    if (!rst) begin
      exp_m = VW'(1);
      exp_l = VW'(1);
    end
    check("outputs_msb", 32'(act_m), 32'(exp_m));
    check("outputs_lsb", 32'(act_l), 32'(exp_l));
  end

  // ---------------- event monitors ----------------
  logic sq[$];
  int n_stcp = 0, n_done = 0, n_hs = 0, cap_n = 0;
  logic p_sck = 1'b0, p_stcp = 1'b0, p_sclk = 1'b0;
  logic [SW-1:0] cap_m [CH];
  logic [SW-1:0] cap_l [CH];
  always @(negedge clk) begin
    if (rst) begin
      if (m_sck && !p_sck) sq.push_back(m_sdat);
      if (m_stcp && !p_stcp) n_stcp++;
      if (m_done) n_done++;
      if (m_ready && data_valid) n_hs++;
      if (m_sclk && !p_sclk && cap_n < SW) begin
        for (int k = 0; k < CH; k++) begin
          cap_m[k] = {cap_m[k][SW-2:0], m_mosi[k]};
          cap_l[k] = {cap_l[k][SW-2:0], l_mosi[k]};
        end
        cap_n++;
      end
    end
    p_sck = m_sck; p_stcp = m_stcp; p_sclk = m_sclk;
  end

  task automatic check_seq(input string name, input logic [5:0] req);
    check({name, "_count"}, 32'(sq.size()), 32'd6);
    for (int i = 0; i < 6 && i < sq.size(); i++) check(name, 32'(sq[i]), 32'(req[5-i]));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int cnt;
    logic got;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_nen", 32'(m_nen), 32'd1);
    check("reset_spi_clk", 32'(m_sclk), 32'd0);
    check("reset_busy", 32'(m_busy), 32'd0);
    check("reset_ready", 32'(m_ready), 32'd0);

    // Frame 1: directed first word, stall between words, extra_bit fixed at 1.
    extra_bit = 1'b1;
    data_in = {8'hFF, 8'h3C, 8'hA5};
    data_valid = 1'b1;
    sq.delete(); n_stcp = 0; n_done = 0; n_hs = 0;
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(posedge clk); #1;
      got = (n_hs >= 1);
    end
    check("first_handshake_seen", 32'(got), 32'd1);
    data_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_ready) break;
      cnt++;
    end
    check("word_cycles", 32'(cnt), 32'(2*DIV*SW));
    repeat (10) @(posedge clk);
    #1 data_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      data_in = (CH*SW)'($urandom());
      if (i == 30) frame_start = 1'b1;
      if (m_done) begin
        frame_start = 1'b1;
        got = 1'b1;
        break;
      end
    end
    check("frame1_done_seen", 32'(got), 32'd1);
    @(posedge clk); #1 frame_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("frame1_done_count", 32'(n_done), 32'd1);
    check("frame1_idle_busy", 32'(m_busy), 32'd0);
    check("frame1_stcp_count", 32'(n_stcp), 32'(COLS));
    check("frame1_word_count", 32'(n_hs), 32'(COLS*WPC));
    check("frame1_nen_idle", 32'(m_nen), 32'd0);
    check_seq("frame1_ser_data", 6'b110101);
    check("msb_lane0", 32'(cap_m[0]), 32'h0A5);
    check("msb_lane1", 32'(cap_m[1]), 32'h03C);
    check("msb_lane2", 32'(cap_m[2]), 32'h0FF);
    check("lsb_lane0", 32'(cap_l[0]), 32'h0A5);
    check("lsb_lane1", 32'(cap_l[1]), 32'h03C);
    check("lsb_lane2", 32'(cap_l[2]), 32'h0FF);

    // Frame 2: random traffic, reset during BIT_HI of column 1.
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      data_valid = ($urandom_range(0, 9) < 6);
      data_in = (CH*SW)'($urandom());
      extra_bit = 1'($urandom());
      if (m_col == CW'(1) && m_sclk) begin got = 1'b1; break; end
    end
    check("col1_bit_hi_reached", 32'(got), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(m_busy), 32'd0);
    check("midrst_nen", 32'(m_nen), 32'd1);
    check("midrst_spi_clk", 32'(m_sclk), 32'd0);
    check("midrst_mosi", 32'(m_mosi), 32'd0);
    check("midrst_col", 32'(m_col), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;

    // Frame 3: restart after reset, extra_bit fixed at 0.
    extra_bit = 1'b0;
    sq.delete(); n_done = 0;
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      data_valid = ($urandom_range(0, 9) < 5);
      data_in = (CH*SW)'($urandom());
      if (m_done) begin got = 1'b1; break; end
    end
    check("frame3_done_seen", 32'(got), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("frame3_done_count", 32'(n_done), 32'd1);
    check_seq("frame3_ser_data", 6'b100000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_frame_sequencer.md
Name: matrix_frame_sequencer

Overview:
- Successor output stage for the HDMI-to-matrix path. It drives a whole frame autonomously: it walks all columns of the panel chain and streams a parametrised number of SPI words per column on CHANNEL_NUMBER parallel MOSI lanes.
- It contains its own 74HC595-style column-select driver and SPI shifter. It adds a valid/ready data handshake, a configurable SPI clock divider, and blanking during column switches.
- It sits between the line/column buffer (upstream, supplies words) and the board pins (downstream).

Parameters:
- CHANNEL_NUMBER, 3: number of parallel MOSI lanes.
- SPI_SIZE, 8: bits per word per lane.
- MSB_FIRST, 1: 1 = bit SPI_SIZE-1 is shifted first; 0 = bit 0 is shifted first.
- COLUMN_COUNT, 16: columns per frame; must be ≥ 1.
- WORDS_PER_COLUMN, 24: words per lane per column; must be ≥ 1.
- CLK_DIV, 2: clk cycles per spi_clk half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  1-cycle pulse that starts a frame.
- extra_bit  in  1  bit shifted into the column chain after the select bit, on every column step.
- data_in  in  CHANNEL_NUMBER*SPI_SIZE  packed lane words; lane k occupies bits [k*SPI_SIZE +: SPI_SIZE].
- data_valid  in  1  data_in holds a word for every lane.
- data_ready  out  1  sequencer accepts data_in this cycle.
- busy  out  1  frame in progress.
- column_idx  out  $clog2(COLUMN_COUNT) (min 1)  current column.
- frame_done  out  1  1-cycle pulse at the end of a frame.
- spi_clk  out  1  shared SPI clock; idles low; data is sampled by the receivers on the rising edge.
- spi_mosi  out  CHANNEL_NUMBER  per-lane serial data.
- ser_clk, ser_data, ser_stcp  out  1 each  column shift register clock, data and storage latch.
- ser_n_enable  out  1  active-low output enable of the column drivers.

Behaviour:
- Reset values (asynchronous, rst = 0):
  - state = IDLE.
  - All outputs 0, except ser_n_enable = 1 (blanked).
  - Column counter and word counter = 0.
- States: IDLE, COL_SHIFT0, COL_SHIFT1, COL_LATCH, LOAD, BIT_LO, BIT_HI, COL_END.
- IDLE:
  - busy = 0, data_ready = 0.
  - frame_start → column = 0, go to COL_SHIFT0.
  - ser_n_enable keeps its last value in IDLE. It is 1 after reset and 0 after a completed frame.
- Column step, 5 cycles per column:
  - Select bit = 1 when column == 0, else 0.
  - COL_SHIFT0: ser_data = select bit, ser_clk = 0.
  - Next cycle: ser_clk = 1.
  - COL_SHIFT1: ser_data = extra_bit, ser_clk = 0, then ser_clk = 1 in the following cycle.
  - COL_LATCH: ser_stcp = 1 for exactly 1 cycle.
  - ser_n_enable = 1 from entry to COL_SHIFT0 through the COL_LATCH cycle. It goes to 0 in the cycle after COL_LATCH.
- LOAD:
  - data_ready = 1 and spi_clk = 0.
  - On data_valid & data_ready, capture all lanes into shift registers, reset the bit counter and go to BIT_LO.
  - With data_valid = 0 the block stalls indefinitely with spi_clk low; there is no timeout.
- BIT_LO: spi_mosi[k] = current bit of lane k, spi_clk = 0, held for CLK_DIV cycles.
- BIT_HI: spi_clk = 1 and spi_mosi is held stable, for CLK_DIV cycles.
  - If more bits remain, shift and return to BIT_LO.
  - After the last bit: if words sent < WORDS_PER_COLUMN go to LOAD, else go to COL_END.
- Word cost: one word occupies 2*CLK_DIV*SPI_SIZE cycles, plus at least 1 LOAD cycle.
- COL_END:
  - If column == COLUMN_COUNT-1: frame_done = 1 for 1 cycle, column = 0, go to IDLE.
  - Otherwise: column + 1, go to COL_SHIFT0.
- busy = 1 in every state except IDLE. column_idx reflects the column currently being shifted or transmitted.
- spi_mosi = 0 in every state other than BIT_LO and BIT_HI.
- frame_start while busy is ignored; no queuing.
- frame_start arriving in the same cycle as frame_done → ignored; it must be re-issued from IDLE.
- rst asserted mid-operation: immediate return to reset values. Any partial word is discarded. ser_n_enable goes to 1.
- Widths: counters are sized with $clog2 of their terminal value + 1. There is no wrap-around inside a frame.

Test Plan:
- Reset then idle: check ser_n_enable = 1, spi_clk = 0, busy = 0, data_ready = 0. Then frame_start with COLUMN_COUNT=2, WORDS_PER_COLUMN=2, CLK_DIV=1, data_valid held 1 → ser_data pattern: 1, extra_bit, 0, extra_bit. Exactly 2 ser_stcp pulses, 4 words on the SPI lanes, a single frame_done pulse, then busy = 0.
- MSB_FIRST=1, lane words 0xA5, 0x3C, 0xFF → bits captured at spi_clk rising edges are 10100101, 00111100 and 11111111 respectively. Repeat with MSB_FIRST=0 → 10100101, 00111100 and 11111111 read LSB first.
- CLK_DIV=3 → spi_clk high and low phases are 3 cycles each. One word measured from the data_ready handshake to the next LOAD = 48 cycles.
- Drop data_valid for 10 cycles between words → data_ready stays high, spi_clk stays low, no bits are lost, the word count is still exact.
- frame_start pulsed mid-frame, and again in the frame_done cycle → no effect. Only one frame_done is seen.
- rst pulled low during BIT_HI of column 1 → all outputs return to reset values in the same cycle. A new frame_start restarts from column 0 with select bit 1.
